// File: rtl/qpsk_demapper.sv
// Streaming QPSK demapper: equalised Q1.15 symbols in, scaled saturated LLRs and
// hard bits out through a two-stage valid/ready pipeline, plus a hard-bit word packer.
module qpsk_demapper #(
  parameter  int LLR_W     = 8,
  parameter  int SHIFT     = 8,
  parameter  int WORD_SYMS = 8,
  localparam int NSYM_W    = $clog2(WORD_SYMS + 1),
  localparam int WORD_W    = 2 * WORD_SYMS
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [15:0]             i_re,
  input  logic [15:0]             i_im,
  input  logic                    i_last,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic signed [LLR_W-1:0] o_llr0,
  output logic signed [LLR_W-1:0] o_llr1,
  output logic [1:0]              o_b0b1,
  output logic                    o_last,
  output logic                    o_word_valid,
  output logic [WORD_W-1:0]       o_word,
  output logic [NSYM_W-1:0]       o_word_nsym
);

  localparam logic signed [16:0] RND     = 17'(1 << (SHIFT - 1));
  localparam logic signed [16:0] LLR_MAX = 17'((1 << (LLR_W - 1)) - 1);
  localparam logic signed [16:0] LLR_MIN = -LLR_MAX;

  // Sign-extend to 17 bits first so adding the rounding constant cannot overflow.
  function automatic logic signed [16:0] round_add(input logic [15:0] x);
    return $signed({x[15], x}) + RND;
  endfunction

  // Symmetric clamp: the most negative LLR code is never produced.
  function automatic logic signed [LLR_W-1:0] sat_llr(input logic signed [16:0] r);
    logic signed [16:0] l;
    l = r >>> SHIFT;
    if (l > LLR_MAX)      return LLR_MAX[LLR_W-1:0];
    else if (l < LLR_MIN) return LLR_MIN[LLR_W-1:0];
    else                  return l[LLR_W-1:0];
  endfunction

  logic en;
  assign en      = !o_valid || i_ready;
  assign o_ready = en;

  logic                s1_valid;
  logic                s1_b0;
  logic                s1_b1;
  logic                s1_last;
  logic signed [16:0]  s1_r_re;
  logic signed [16:0]  s1_r_im;

  // NOTE: every register in an always_ff uses <= so all flops sample the
  // pre-edge values; a blocking = here would chain stages within one edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_b0    <= 1'b0;
      s1_b1    <= 1'b0;
      s1_last  <= 1'b0;
      s1_r_re  <= '0;
      s1_r_im  <= '0;
    end else if (en) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_b0   <= i_re[15];
        s1_b1   <= i_im[15];
        s1_last <= i_last;
        s1_r_re <= round_add(i_re);
        s1_r_im <= round_add(i_im);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_llr0  <= '0;
      o_llr1  <= '0;
      o_b0b1  <= 2'b00;
      o_last  <= 1'b0;
    end else if (en) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_llr0 <= sat_llr(s1_r_re);
        o_llr1 <= sat_llr(s1_r_im);
        o_b0b1 <= {s1_b1, s1_b0};
        o_last <= s1_last;
      end
    end
  end

  logic                hs;
  logic                word_done;
  logic [NSYM_W-1:0]   cnt;
  logic [NSYM_W-1:0]   cnt_inc;
  logic [WORD_W-1:0]   acc;
  logic [WORD_W-1:0]   acc_ins;

  assign hs = o_valid && i_ready;

  // NOTE: each always_comb output gets a default before any conditional
  // assignment, otherwise untaken paths would infer latches.
  always_comb begin
    cnt_inc = cnt + NSYM_W'(1);
    acc_ins = acc;
    for (int k = 0; k < WORD_SYMS; k++) begin
      if (cnt == NSYM_W'(k)) acc_ins[2*k +: 2] = o_b0b1;
    end
    word_done = hs && ((cnt_inc == NSYM_W'(WORD_SYMS)) || o_last);
  end

  // Accumulator clears on emission so unfilled high symbols of a short word read zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt          <= '0;
      acc          <= '0;
      o_word_valid <= 1'b0;
      o_word       <= '0;
      o_word_nsym  <= '0;
    end else begin
      o_word_valid <= word_done;
      if (word_done) begin
        o_word      <= acc_ins;
        o_word_nsym <= cnt_inc;
        acc         <= '0;
        cnt         <= '0;
      end else if (hs) begin
        acc <= acc_ins;
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_qpsk_demapper.sv
// Self-checking bench for qpsk_demapper: directed constellation/edge/packing/reset
// steps followed by a randomized backpressured stream scored against a queue model.
`timescale 1ns/1ps
module tb_qpsk_demapper;

  localparam int LLR_W     = 8;
  localparam int SHIFT     = 8;
  localparam int WORD_SYMS = 8;

  logic              i_clk;
  logic              i_rst;
  logic              i_valid;
  logic              o_ready;
  logic [15:0]       i_re;
  logic [15:0]       i_im;
  logic              i_last;
  logic              o_valid;
  logic              i_ready;
  logic signed [7:0] o_llr0;
  logic signed [7:0] o_llr1;
  logic [1:0]        o_b0b1;
  logic              o_last;
  logic              o_word_valid;
  logic [15:0]       o_word;
  logic [3:0]        o_word_nsym;

  qpsk_demapper #(.LLR_W(LLR_W), .SHIFT(SHIFT), .WORD_SYMS(WORD_SYMS)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_re(i_re), .i_im(i_im), .i_last(i_last), .o_valid(o_valid),
    .i_ready(i_ready), .o_llr0(o_llr0), .o_llr1(o_llr1), .o_b0b1(o_b0b1),
    .o_last(o_last), .o_word_valid(o_word_valid), .o_word(o_word),
    .o_word_nsym(o_word_nsym)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    int         llr0;
    int         llr1;
    logic [1:0] b0b1;
    logic       last;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];
  logic [1:0]  wpairs[$];
  logic        wv_next = 1'b0;
  logic [15:0] exp_word = '0;
  int          exp_nsym = 0;
  int          word_pulses = 0;
  logic [15:0] last_word = '0;
  int          last_nsym = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(observed), $signed(expected));
    end
  endtask

  // Reference LLR: floor((x + 2^(SHIFT-1)) / 2^SHIFT), clamped to +/-(2^(LLR_W-1)-1).
  function automatic int model_llr(input logic [15:0] x);
    int v, q, lim, d;
    d = 1 << SHIFT;
    v = int'($signed(x)) + (1 << (SHIFT - 1));
    if (v >= 0) q = v / d;
    else        q = -((-v + d - 1) / d);
    lim = (1 << (LLR_W - 1)) - 1;
    if (q > lim)  q = lim;
    if (q < -lim) q = -lim;
    return q;
  endfunction

  function automatic exp_t model(input logic [15:0] re, input logic [15:0] im, input logic last);
    exp_t e;
    e.llr0 = model_llr(re);
    e.llr1 = model_llr(im);
    e.b0b1 = {($signed(im) < 0), ($signed(re) < 0)};
    e.last = last;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [15:0] re, input logic [15:0] im,
                       input logic last, input logic rdy);
    i_valid = v;
    i_re    = re;
    i_im    = im;
    i_last  = last;
    i_ready = rdy;
  endtask

  // One clock: score outputs just before the edge, advance, then check the word channel.
  task automatic tick(output bit accepted);
    exp_t e;
    #2;
    check("o_ready_rule", 32'(o_ready), 32'(!o_valid || i_ready));
    if (o_valid) begin
      check("out_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check("llr0", 32'($signed(o_llr0)), e.llr0);
        check("llr1", 32'($signed(o_llr1)), e.llr1);
        check("b0b1", 32'(o_b0b1), 32'(e.b0b1));
        check("last", 32'(o_last), 32'(e.last));
        if (i_ready) begin
          void'(exp_q.pop_front());
          wpairs.push_back(e.b0b1);
          if (wpairs.size() == WORD_SYMS || e.last) begin
            exp_word = '0;
            foreach (wpairs[i]) exp_word[2*i +: 2] = wpairs[i];
            exp_nsym = wpairs.size();
            wv_next  = 1'b1;
            wpairs.delete();
          end
        end
      end
    end
    accepted = i_valid && o_ready;
    if (accepted) exp_q.push_back(model(i_re, i_im, i_last));
    @(posedge i_clk);
    #1;
    check("word_valid", 32'(o_word_valid), 32'(wv_next));
    if (o_word_valid) begin
      word_pulses++;
      last_word = o_word;
      last_nsym = int'(o_word_nsym);
    end
    if (wv_next) begin
      check("word_bits", 32'(o_word), 32'(exp_word));
      check("word_nsym", 32'(o_word_nsym), exp_nsym);
    end
    wv_next = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(posedge i_clk);
    #1;
    check("rst_o_valid", 32'(o_valid), 0);
    check("rst_llr0", 32'($signed(o_llr0)), 0);
    check("rst_llr1", 32'($signed(o_llr1)), 0);
    check("rst_b0b1", 32'(o_b0b1), 0);
    check("rst_last", 32'(o_last), 0);
    check("rst_word_valid", 32'(o_word_valid), 0);
    check("rst_word", 32'(o_word), 0);
    check("rst_word_nsym", 32'(o_word_nsym), 0);
    check("rst_o_ready", 32'(o_ready), 1);
    exp_q.delete();
    wpairs.delete();
    wv_next = 1'b0;
    i_rst = 1'b0;
  endtask

  task automatic one(input logic [15:0] re, input logic [15:0] im);
    bit a;
    drive(1'b1, re, im, 1'b0, 1'b1);
    tick(a);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    tick(a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish by 200us, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit a;
    int wp;
    logic [15:0] pat_re[4];
    logic [15:0] pat_im[4];
    pat_re = '{16'h5A82, 16'hA57E, 16'h5A82, 16'hA57E};
    pat_im = '{16'h5A82, 16'h5A82, 16'hA57E, 16'hA57E};
    i_rst = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

    // Nominal point and two-cycle latency.
    do_reset();
    drive(1'b1, 16'h5A82, 16'h5A82, 1'b0, 1'b1);
    tick(a);
    check("lat_t1_idle", 32'(o_valid), 0);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    tick(a);
    check("lat_t2_valid", 32'(o_valid), 1);
    check("nom_llr0", 32'($signed(o_llr0)), 91);
    check("nom_llr1", 32'($signed(o_llr1)), 91);
    check("nom_b0b1", 32'(o_b0b1), 0);
    tick(a);

    // Back-to-back mixed-sign points.
    do_reset();
    drive(1'b1, 16'hA57E, 16'h5A82, 1'b0, 1'b1);
    tick(a);
    drive(1'b1, 16'h5A82, 16'hA57E, 1'b0, 1'b1);
    tick(a);
    check("mix1_llr0", 32'($signed(o_llr0)), -91);
    check("mix1_llr1", 32'($signed(o_llr1)), 91);
    check("mix1_b0b1", 32'(o_b0b1), 32'(2'b01));
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    tick(a);
    check("mix2_llr0", 32'($signed(o_llr0)), 91);
    check("mix2_llr1", 32'($signed(o_llr1)), -91);
    check("mix2_b0b1", 32'(o_b0b1), 32'(2'b10));
    tick(a);

    // Saturation and zero/minus-one edges.
    do_reset();
    one(16'h7FFF, 16'h0000);
    check("sat_pos_llr0", 32'($signed(o_llr0)), 127);
    one(16'h8000, 16'h0000);
    check("sat_neg_llr0", 32'($signed(o_llr0)), -127);
    check("sat_neg_b0", 32'(o_b0b1[0]), 1);
    one(16'h0000, 16'h0000);
    check("zero_llr0", 32'($signed(o_llr0)), 0);
    check("zero_b0", 32'(o_b0b1[0]), 0);
    one(16'hFFFF, 16'h0000);
    check("m1_llr0", 32'($signed(o_llr0)), 0);
    check("m1_b0", 32'(o_b0b1[0]), 1);
    tick(a);

    // Full 8-symbol word, then a 3-symbol frame closed by i_last.
    do_reset();
    wp = word_pulses;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, pat_re[k % 4], pat_im[k % 4], 1'b0, 1'b1);
      tick(a);
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    repeat (4) tick(a);
    check("word8_pulses", word_pulses - wp, 1);
    check("word8_bits", 32'(last_word), 32'(16'hE4E4));
    check("word8_nsym", last_nsym, 8);
    drive(1'b1, 16'hA57E, 16'hA57E, 1'b0, 1'b1); tick(a);
    drive(1'b1, 16'h5A82, 16'h5A82, 1'b0, 1'b1); tick(a);
    drive(1'b1, 16'hA57E, 16'h5A82, 1'b1, 1'b1); tick(a);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    repeat (4) tick(a);
    check("word3_pulses", word_pulses - wp, 2);
    check("word3_bits", 32'(last_word), 32'(16'h0013));
    check("word3_nsym", last_nsym, 3);

    // Reset with a 5-symbol partial word and two symbols in flight.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, pat_re[k % 4], pat_im[k % 4], 1'b0, 1'b1);
      tick(a);
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    repeat (3) tick(a);
    drive(1'b1, 16'hA57E, 16'hA57E, 1'b0, 1'b1); tick(a);
    drive(1'b1, 16'hA57E, 16'h5A82, 1'b0, 1'b1); tick(a);
    check("inflight_valid", 32'(o_valid), 1);
    wp = word_pulses;
    do_reset();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    repeat (3) tick(a);
    check("rst_no_word", word_pulses - wp, 0);
    drive(1'b1, 16'hA57E, 16'hA57E, 1'b0, 1'b1); tick(a);
    drive(1'b1, 16'hA57E, 16'hA57E, 1'b0, 1'b1); tick(a);
    drive(1'b1, 16'hA57E, 16'hA57E, 1'b1, 1'b1); tick(a);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    repeat (4) tick(a);
    check("post_rst_pulses", word_pulses - wp, 1);
    check("post_rst_bits", 32'(last_word), 32'(16'h003F));
    check("post_rst_nsym", last_nsym, 3);

    // Randomized stream with random backpressure; the queue model scores every output.
    begin
      int          acc_n = 0;
      int          cyc   = 0;
      bit          have  = 0;
      logic [15:0] re = '0, im = '0;
      logic        last = 1'b0;
      do_reset();
      while (acc_n < 200 && cyc < 5000) begin
        if (!have && $urandom_range(3) != 0) begin
          re   = 16'($urandom);
          im   = 16'($urandom);
          last = ($urandom_range(15) == 0);
          have = 1;
        end
        drive(have, re, im, last, 1'($urandom_range(1)));
        tick(a);
        cyc++;
        if (a) begin
          have = 0;
          acc_n++;
        end
      end
      check("rand_accepted", acc_n, 200);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick(a);
      check("rand_drained", exp_q.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
